// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: start/busy/done handshake and operand/result bus for
// the bit-serial adder sequencer.
//   master : requester (drives start, a, b, cin; sees busy, done, sum, cout)
//   slave  : sequencer (the reverse)
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output start, a, b, cin, input  busy, done, sum, cout);
    modport slave  (input  start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: drives one external 1-bit full-adder cell across WIDTH
// cycles, LSB first, holding the ripple carry in a flop between bits.
//   clk, rst_n      : clock, synchronous active-low reset
//   bus (slave)     : start/a/b/cin in, busy/done/sum/cout out
//   fa_a/fa_b/fa_ci : operand and carry bits to the full-adder cell
//   fa_s/fa_co      : combinational sum/carry back from the cell
// Timing: start accepted at edge k, RUN for WIDTH cycles, done pulses in
// the cycle after edge k+WIDTH, then back to IDLE.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_ctrl_if.slave  bus,
    output logic              fa_a,
    output logic              fa_b,
    output logic              fa_ci,
    input  logic              fa_s,
    input  logic              fa_co
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, sum_r;
    logic             carry, cout_r;
    logic [CW-1:0]    cnt;
    logic             last_bit;

    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_nx = state;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        fa_a     = 1'b0;
        fa_b     = 1'b0;
        fa_ci    = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nx = RUN;
            RUN: begin
                bus.busy = 1'b1;
                fa_a     = a_sh[0];
                fa_b     = b_sh[0];
                fa_ci    = carry;
                if (last_bit) state_nx = DONE;
            end
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            cnt    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (bus.start) begin
                    a_sh  <= bus.a;
                    b_sh  <= bus.b;
                    carry <= bus.cin;
                    cnt   <= '0;
                end
                RUN: begin
                    // Sum bits enter at the MSB so after WIDTH shifts the
                    // first (LSB) result bit has landed in sum_r[0].
                    sum_r <= (sum_r >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                    carry <= fa_co;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) cout_r <= fa_co;
                end
                default: ;
            endcase
        end
    end
endmodule
